// File: rtl/prescaled_mod_counter_pkg.sv
// Shared constants and helpers for the timekeeping digit counters.
// Default clock rate, standard digit moduli, and direction decoding.
package prescaled_mod_counter_pkg;

  localparam int CLK_HZ  = 50_000_000;
  localparam int DIV_1HZ = CLK_HZ;

  localparam int MOD_DEC  = 10;
  localparam int MOD_SEX  = 6;
  localparam int MOD_H24  = 24;
  localparam int MOD_H12  = 12;
  localparam int MOD_HT24 = 3;
  localparam int MOD_H4   = 4;

  typedef enum logic [1:0] {
    DIR_HOLD,
    DIR_UP,
    DIR_DOWN
  } dir_e;

  function automatic dir_e dir_of(
    input logic up,
    input logic dn
  );
    if (up && !dn) return DIR_UP;
    if (dn && !up) return DIR_DOWN;
    return DIR_HOLD;
  endfunction

  function automatic int presc_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/prescaled_mod_counter_tick_prescaler.sv
// Free-running tick prescaler: step_ok once every DIV cycles,
// plus a registered copy for daisy-chaining.
module tick_prescaler
  import prescaled_mod_counter_pkg::*;
#(
  parameter int DIV = DIV_1HZ
) (
  input  logic clk,
  input  logic reset,
  output logic step_ok,
  output logic tick
);

  localparam int PW = presc_w(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("tick_prescaler: DIV must be >= 1");
  end

  logic [PW-1:0] cnt;

  assign step_ok = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= step_ok ? '0 : cnt + 1'b1;
      tick <= step_ok;
    end
  end

endmodule

// File: rtl/prescaled_mod_counter.sv
// Up/down modulo-N display digit with alternate modulus, preload,
// and registered carry/borrow pulses for cascading.
module prescaled_mod_counter
  import prescaled_mod_counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = MOD_DEC,
  parameter int ALT_MODULUS = MOD_H4,
  parameter int DIV         = DIV_1HZ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             count_up,
  input  logic             count_down,
  input  logic             alt_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc_up,
  output logic             tc_down,
  output logic             tick
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_mod
    $error("prescaled_mod_counter: MODULUS out of range");
  end
  if (ALT_MODULUS < 1 || ALT_MODULUS > MODULUS) begin : g_bad_alt
    $error("prescaled_mod_counter: ALT_MODULUS out of range");
  end

  localparam logic [WIDTH-1:0] TOP_N = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] TOP_A = WIDTH'(ALT_MODULUS - 1);

  logic             step_ok;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] nxt;
  logic             nxt_up;
  logic             nxt_dn;
  logic             step;
  logic             do_ld;
  logic             do_up;
  logic             do_dn;
  dir_e             dir;

  tick_prescaler #(
    .DIV(DIV)
  ) u_presc (
    .clk    (clk),
    .reset  (reset),
    .step_ok(step_ok),
    .tick   (tick)
  );

  assign top   = alt_mode ? TOP_A : TOP_N;
  assign dir   = dir_of(count_up, count_down);
  assign step  = step_ok && en && !load;
  assign do_ld = load;
  assign do_up = step && (dir == DIR_UP);
  assign do_dn = step && (dir == DIR_DOWN);

  always_comb begin
    nxt    = count;
    nxt_up = 1'b0;
    nxt_dn = 1'b0;
    unique case (1'b1)
      do_ld: begin
        nxt = (load_val > top) ? top : load_val;
      end
      do_up: begin
        if (count >= top) begin
          nxt    = '0;
          nxt_up = 1'b1;
        end else begin
          nxt = count + 1'b1;
        end
      end
      do_dn: begin
        if (count == '0) begin
          nxt    = top;
          nxt_dn = 1'b1;
        end else if (count > top) begin
          nxt = top;
        end else begin
          nxt = count - 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      tc_up   <= 1'b0;
      tc_down <= 1'b0;
    end else begin
      count   <= nxt;
      tc_up   <= nxt_up;
      tc_down <= nxt_dn;
    end
  end

endmodule

// File: tb/tb_prescaled_mod_counter.sv
// Self-checking bench for prescaled_mod_counter (W=4, M=10, A=4, DIV=4).
// Integer reference model plus load table and directed corner sequences.
module tb_prescaled_mod_counter;

  localparam int W = 4;
  localparam int M = 10;
  localparam int A = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         count_up;
  logic         count_down;
  logic         alt_mode;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         tc_up;
  logic         tc_down;
  logic         tick;

  always #5 clk = ~clk;

  prescaled_mod_counter #(
    .WIDTH      (W),
    .MODULUS    (M),
    .ALT_MODULUS(A),
    .DIV        (D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .count_up  (count_up),
    .count_down(count_down),
    .alt_mode  (alt_mode),
    .load      (load),
    .load_val  (load_val),
    .count     (count),
    .tc_up     (tc_up),
    .tc_down   (tc_down),
    .tick      (tick)
  );

  int errors = 0;
  int checks = 0;

  int m_cnt = 0;
  int m_ph  = 0;
  int m_tk  = 0;
  int m_tu  = 0;
  int m_td  = 0;

  typedef struct {
    logic alt;
    int   val;
    int   exp;
  } ld_t;

  ld_t lt[8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int top;
    bit ok;
    if (reset) begin
      m_cnt = 0; m_ph = 0; m_tk = 0; m_tu = 0; m_td = 0;
      return;
    end
    ok   = (m_ph == D - 1);
    m_ph = (m_ph + 1) % D;
    m_tk = ok;
    top  = alt_mode ? A - 1 : M - 1;
    m_tu = 0;
    m_td = 0;
    if (load) begin
      m_cnt = (int'(load_val) < top) ? int'(load_val) : top;
    end else if (ok && en && (count_up != count_down)) begin
      if (count_up) begin
        if (m_cnt >= top) begin
          m_cnt = 0; m_tu = 1;
        end else m_cnt = m_cnt + 1;
      end else begin
        if (m_cnt == 0) begin
          m_cnt = top; m_td = 1;
        end else if (m_cnt > top) m_cnt = top;
        else m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk("count", int'(count), m_cnt);
    chk("tc_up", int'(tc_up), m_tu);
    chk("tc_down", int'(tc_down), m_td);
    chk("tick", int'(tick), m_tk);
  endtask

  task automatic idle();
    reset = 0; en = 0; count_up = 0; count_down = 0;
    alt_mode = 0; load = 0; load_val = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    cyc();
    reset = 0;
  endtask

  task automatic do_load(input logic alt, input int v);
    alt_mode = alt; load = 1; load_val = W'(v);
    cyc();
    load = 0;
  endtask

  initial begin
    int nu, nt, n;
    bit found;
    lt[0] = '{1'b0, 12, 9};
    lt[1] = '{1'b1, 12, 3};
    lt[2] = '{1'b0, 5, 5};
    lt[3] = '{1'b1, 2, 2};
    lt[4] = '{1'b0, 15, 9};
    lt[5] = '{1'b1, 3, 3};
    lt[6] = '{1'b1, 0, 0};
    lt[7] = '{1'b0, 9, 9};

    idle();
    @(negedge clk);
    do_reset();
    chk("rst_count", int'(count), 0);
    chk("rst_tick", int'(tick), 0);

    en = 1; count_up = 1;
    nu = 0; nt = 0;
    for (int i = 0; i < 44; i++) begin
      cyc();
      if (tc_up) begin
        nu++;
        chk("carry_at_zero", int'(count), 0);
      end
      if (tick) nt++;
    end
    chk("up_carries", nu, 1);
    chk("up_ticks", nt, 11);
    chk("up_final", int'(count), 1);

    idle();
    do_reset();
    en = 1; count_down = 1;
    for (int i = 0; i < D; i++) cyc();
    chk("dn_first", int'(count), 9);
    chk("dn_borrow", int'(tc_down), 1);
    for (int i = 0; i < D; i++) cyc();
    chk("dn_second", int'(count), 8);
    chk("dn_no_borrow", int'(tc_down), 0);

    idle();
    do_load(1'b0, 7);
    alt_mode = 1;
    for (int i = 0; i < 2 * D; i++) cyc();
    chk("alt_hold", int'(count), 7);
    en = 1; count_up = 1;
    for (int i = 0; i < 2 * D; i++) begin
      cyc();
      if (tick) break;
    end
    chk("alt_up_cnt", int'(count), 0);
    chk("alt_up_tc", int'(tc_up), 1);

    idle();
    do_load(1'b0, 7);
    alt_mode = 1; en = 1; count_down = 1;
    for (int i = 0; i < 2 * D; i++) begin
      cyc();
      if (tick) break;
    end
    chk("alt_dn_cnt", int'(count), 3);
    chk("alt_dn_tc", int'(tc_down), 0);

    idle();
    en = 1; count_up = 1;
    foreach (lt[i]) begin
      do_load(lt[i].alt, lt[i].val);
      chk("load_tbl", int'(count), lt[i].exp);
      chk("load_tbl_up", int'(tc_up), 0);
      chk("load_tbl_dn", int'(tc_down), 0);
    end

    idle();
    do_load(1'b0, 5);
    en = 1; count_up = 1; count_down = 1;
    nu = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (tc_up || tc_down) nu++;
    end
    chk("both_hold", int'(count), 5);
    chk("both_pulses", nu, 0);

    count_down = 0;
    for (int i = 0; i < D && m_ph != D - 1; i++) cyc();
    load = 1; load_val = W'(2);
    cyc();
    load = 0;
    chk("load_beats_step", int'(count), 2);
    chk("load_step_tick", int'(tick), 1);

    idle();
    do_reset();
    en = 1; count_up = 1;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (m_cnt == 5 && m_ph == 2) begin
        found = 1;
        break;
      end
    end
    chk("mid_found", int'(found), 1);
    reset = 1;
    cyc();
    reset = 0;
    chk("mid_rst_cnt", int'(count), 0);
    chk("mid_rst_tick", int'(tick), 0);
    n = 0;
    for (int i = 0; i < 3 * D; i++) begin
      cyc();
      n++;
      if (tick) break;
    end
    chk("first_tick_gap", n, D);

    idle();
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 49) == 0);
      load       = ($urandom_range(0, 15) == 0);
      load_val   = W'($urandom_range(0, 15));
      en         = ($urandom_range(0, 3) != 0);
      count_up   = 1'($urandom);
      count_down = 1'($urandom);
      alt_mode   = ($urandom_range(0, 4) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prescaled_mod_counter.md
Name: prescaled_mod_counter

Overview:
- Parametrised up/down modulo-N digit counter with an integrated tick prescaler.
- Supersedes the fixed mod-10 and hours-limited digit counters: one block covers every clock/alarm digit (seconds, minutes, hours units/tens).
- Adds a runtime alternate modulus, synchronous preload, and registered carry/borrow pulses for cascading digits.
- Instantiated once per display digit in the timekeeping datapath.

Parameters:
- WIDTH, 4: bit width of the count value.
- MODULUS, 10: normal modulus. Count range is 0..MODULUS-1. Legal range is 2..2^WIDTH.
- ALT_MODULUS, 4: modulus used when alt_mode=1 (e.g. hours-tens or 24h limit). Legal range is 1..MODULUS.
- DIV, 50000000: prescaler period in clk cycles. One step opportunity per DIV cycles. Legal minimum is 1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  enables counting on tick cycles.
- count_up  in  1  request increment.
- count_down  in  1  request decrement.
- alt_mode  in  1  selects ALT_MODULUS instead of MODULUS.
- load  in  1  synchronous preload strobe.
- load_val  in  WIDTH  preload value.
- count  out  WIDTH  current digit value (registered).
- tc_up  out  1  one-cycle pulse: wrapped top->0 (carry).
- tc_down  out  1  one-cycle pulse: wrapped 0->top (borrow).
- tick  out  1  one-cycle registered prescaler pulse, for daisy-chained timing.

Behaviour:
- Reset (clk edge with reset=1): count=0, prescaler=0, tick=0, tc_up=0, tc_down=0. Reset has priority over everything.
- Prescaler:
  - Free-runs 0..DIV-1 regardless of en, load or direction.
  - Internal step_ok is true in the cycle the prescaler equals DIV-1; the prescaler then returns to 0.
  - tick is step_ok registered: high for exactly 1 cycle every DIV cycles. The first tick is visible DIV cycles after reset deasserts.
  - DIV=1 means step_ok every cycle, and tick stays high from the second cycle after reset.
- top = alt_mode ? ALT_MODULUS-1 : MODULUS-1. Evaluated combinationally each cycle.
- Priority per edge: reset > load > step > hold.
- Load:
  - count <= min(load_val, top).
  - Not gated by en or step_ok.
  - tc_up and tc_down = 0 on that edge.
  - Prescaler is unaffected.
- Step occurs when step_ok && en && (count_up XOR count_down). Both or neither direction asserted means hold.
  - Up, count < top: count+1, no pulse.
  - Up, count == top: count <= 0, tc_up=1 next cycle.
  - Up, count > top (alt_mode just raised): count <= 0, tc_up=1.
  - Down, count == 0: count <= top, tc_down=1.
  - Down, 0 < count <= top: count-1, no pulse.
  - Down, count > top: count <= top, no pulse.
- Hold: count unchanged even when out of range. Range is only corrected by a step or a load.
- tc_up and tc_down are registered with count, so they are high in the same cycle as the new value. They last exactly one cycle and are never high simultaneously.
- ALT_MODULUS=1: top=0. Every up step yields count=0 with tc_up; every down step yields 0 with tc_down.
- Reset mid-count: state clears on that edge, and prescaler phase restarts from 0.
- Arithmetic: internal compares are WIDTH wide. Prescaler width is clog2(DIV), with a minimum of 1. No overflow is possible given the legal parameter ranges.
- Illegal parameters are flagged by an elaboration-time check (simulation $error) and are not synthesised.

Decomposition:
- Shared constants header holds the default clock frequency (50 MHz -> DIV for 1 Hz) and the standard moduli (10, 6, 24, 12, 3, 4) used by the digit instances.
- One sub-module, tick_prescaler (parameter DIV; ports clk, reset, step_ok, tick), replaces the old clock-divider instance.
- Counting/wrap logic stays in prescaled_mod_counter.

Test Plan:
All scenarios use WIDTH=4, MODULUS=10, ALT_MODULUS=4, DIV=4.
- Reset then en=1, count_up=1 for 44 cycles -> count steps every 4 cycles (0,1,…,9,0). tc_up pulses once, in the cycle count becomes 0. tick period is 4.
- count_down=1 from reset -> first step gives count=9 with tc_down pulse; the next step gives 8.
- count=7, raise alt_mode, hold with en=0 -> count stays 7. Next up step -> 0 with tc_up. Alternatively, next down step -> 3 with no pulse.
- load=1, load_val=12 with alt_mode=0 -> count=9 on the next edge. With alt_mode=1 -> count=3. tc_up and tc_down stay 0. Tick spacing is unchanged.
- count_up=count_down=1 for 20 cycles -> count holds and no pulses. load on a step_ok cycle wins over the step.
- reset asserted mid-run at count=5, prescaler=2 -> next cycle count=0 and all outputs 0. The first tick arrives 4 cycles after reset drops.
